// File: rtl/ecs3_rx_pkg.sv
// Shared definitions for the ECS3 receiver: state encoding, field widths and
// the index-burst ordering helpers.
`timescale 1ns/1ps
package ecs3_rx_pkg;

  localparam int unsigned NOI_W     = 2;
  localparam int unsigned IND_W     = 3;
  localparam int unsigned IND_BASE  = 1;
  localparam int unsigned MAX_BURST = 16;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_NOI,
    ST_IDX,
    ST_FLAGS
  } rx_state_e;

  // Steps inside a segment: 0 Ind0_lo, 1 Ind1_lo, 2 Ind0_hi, 3 Ind1_hi.
  function automatic logic step_needed(input logic [1:0] step,
                                       input logic [NOI_W-1:0] noi_lo,
                                       input logic [NOI_W-1:0] noi_hi);
    logic need;
    unique case (step)
      2'd0:    need = (noi_lo != '0);
      2'd1:    need = (noi_lo == 2'd2);
      2'd2:    need = (noi_hi != '0);
      default: need = (noi_hi == 2'd2);
    endcase
    return need;
  endfunction

  // First required step at or after 'from'; 3'd4 when the segment is complete.
  function automatic logic [2:0] next_step(input logic [2:0] from,
                                           input logic [NOI_W-1:0] noi_lo,
                                           input logic [NOI_W-1:0] noi_hi);
    logic [2:0] r;
    r = 3'd4;
    for (int unsigned i = 4; i > 0; i--) begin
      if ((i - 1) >= 32'(from) && step_needed(2'(i - 1), noi_lo, noi_hi))
        r = 3'(i - 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/ecs3_rx_decoder.sv
// Rebuilds one data nibble from its received {NOI, Ind0, Ind1, Flag} fields.
`timescale 1ns/1ps
module ecs3_decoder
  import ecs3_rx_pkg::*;
(
  input  logic [NOI_W-1:0] noi,
  input  logic [IND_W-1:0] ind0,
  input  logic [IND_W-1:0] ind1,
  input  logic             flag,
  output logic [3:0]       nibble
);

  logic [3:0] coded;

  always_comb begin
    coded = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (noi != '0 && ind0 == IND_W'(b + IND_BASE))
        coded[b] = 1'b1;
      if (noi == 2'd2 && ind1 == IND_W'(b + IND_BASE))
        coded[b] = 1'b1;
    end
    nibble = flag ? ~coded : coded;
  end

endmodule

// File: rtl/ecs3_rx.sv
// ECS3 single-wire receiver: counts pulse bursts, rebuilds per-nibble encoder
// fields and presents the decoded 16-bit word with a one-cycle valid strobe.
`timescale 1ns/1ps
module ecs3_rx
  import ecs3_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        ECS3_TRX_Clock,
  input  logic        nRST,
  input  logic        RXSelect,
  input  logic        ECS3_In,
  output logic [15:0] RXData_Out,
  output logic        RXValid,
  output logic        RXError,
  output logic        RXBusy
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

  rx_state_e              state_q, state_d;
  logic                   s_q, s_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic                   seg_q, seg_d;
  logic [1:0]             step_q, step_d;
  logic [3:0][NOI_W-1:0]  noi_q, noi_d;
  logic [3:0][IND_W-1:0]  ind0_q, ind0_d;
  logic [3:0][IND_W-1:0]  ind1_q, ind1_d;
  logic [15:0]            data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   error_q, error_d;

  logic [3:0]       burst_m1;
  logic [NOI_W-1:0] field_lo, field_hi;
  logic [1:0]       lo_idx, hi_idx, idx_nib;
  logic [15:0]      decoded;
  logic             abort, route;
  logic [2:0]       nxt;

  // The NOI/flags value is count-1; mod-16 arithmetic maps a 16-pulse burst to 15.
  assign burst_m1 = cnt_q[3:0] - 4'd1;
  assign field_lo = burst_m1[1:0];
  assign field_hi = burst_m1[3:2];
  assign lo_idx   = {seg_q, 1'b0};
  assign hi_idx   = {seg_q, 1'b1};
  assign idx_nib  = {seg_q, step_q[1]};
  assign s_d      = ECS3_In;

  for (genvar g = 0; g < 4; g++) begin : g_dec
    ecs3_decoder u_dec (
      .noi    (noi_q[g]),
      .ind0   (ind0_q[g]),
      .ind1   (ind1_q[g]),
      .flag   (burst_m1[g]),
      .nibble (decoded[4*g +: 4])
    );
  end

  always_ff @(negedge ECS3_TRX_Clock or negedge nRST) begin
    if (!nRST) s_q <= 1'b0;
    else       s_q <= s_d;
  end

  always_ff @(posedge ECS3_TRX_Clock or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      seg_q   <= 1'b0;
      step_q  <= '0;
      noi_q   <= '0;
      ind0_q  <= '0;
      ind1_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      seg_q   <= seg_d;
      step_q  <= step_d;
      noi_q   <= noi_d;
      ind0_q  <= ind0_d;
      ind1_q  <= ind1_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    seg_d   = seg_q;
    step_d  = step_q;
    noi_d   = noi_q;
    ind0_d  = ind0_q;
    ind1_d  = ind1_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    abort   = 1'b0;
    route   = 1'b0;
    nxt     = 3'd4;

    if (!RXSelect) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (s_q) begin
      gap_d = '0;
      if (cnt_q == CNT_W'(MAX_BURST)) abort = 1'b1;
      else                            cnt_d = cnt_q + 1'b1;
      if (state_q == ST_IDLE) begin
        state_d = ST_NOI;
        seg_d   = 1'b0;
      end
    end else begin
      if (state_q != ST_IDLE) begin
        if (gap_q == GAP_W'(TIMEOUT)) abort = 1'b1;
        else                          gap_d = gap_q + 1'b1;
      end
      if (cnt_q != '0) begin
        cnt_d = '0;
        unique case (state_q)
          ST_NOI: begin
            if (field_lo == 2'd3 || field_hi == 2'd3) begin
              abort = 1'b1;
            end else begin
              noi_d[lo_idx]  = field_lo;
              noi_d[hi_idx]  = field_hi;
              ind0_d[lo_idx] = '0;
              ind0_d[hi_idx] = '0;
              ind1_d[lo_idx] = '0;
              ind1_d[hi_idx] = '0;
              nxt   = next_step(3'd0, field_lo, field_hi);
              route = 1'b1;
            end
          end
          ST_IDX: begin
            if (cnt_q > CNT_W'(4)) begin
              abort = 1'b1;
            end else if (!step_q[0]) begin
              ind0_d[idx_nib] = cnt_q[IND_W-1:0];
            end else if (cnt_q[IND_W-1:0] <= ind0_q[idx_nib]) begin
              abort = 1'b1;
            end else begin
              ind1_d[idx_nib] = cnt_q[IND_W-1:0];
            end
            if (!abort) begin
              nxt   = next_step({1'b0, step_q} + 3'd1, noi_q[lo_idx], noi_q[hi_idx]);
              route = 1'b1;
            end
          end
          ST_FLAGS: begin
            data_d  = decoded;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end
          default: ;
        endcase
      end
    end

    // Shared routing after an NOI or index burst: next index, next segment or flags.
    if (route) begin
      if (!nxt[2]) begin
        step_d  = nxt[1:0];
        state_d = ST_IDX;
      end else if (!seg_q) begin
        seg_d   = 1'b1;
        state_d = ST_NOI;
      end else begin
        state_d = ST_FLAGS;
      end
    end

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      error_d = 1'b1;
    end

    if (state_d == ST_IDLE) gap_d = '0;
  end

  assign RXData_Out = data_q;
  assign RXValid    = valid_q;
  assign RXError    = error_q;
  assign RXBusy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ecs3_rx.sv
// Directed bench for ecs3_rx: hand-encoded burst sequences with known words and errors.
`timescale 1ns/1ps
module tb_ecs3_rx;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        nRST;
  logic        RXSelect;
  logic        ECS3_In;
  logic [15:0] RXData_Out;
  logic        RXValid;
  logic        RXError;
  logic        RXBusy;

  int n_checks = 0;
  int n_errors = 0;

  ecs3_rx #(.TIMEOUT(TIMEOUT)) dut (
    .ECS3_TRX_Clock (clk),
    .nRST           (nRST),
    .RXSelect       (RXSelect),
    .ECS3_In        (ECS3_In),
    .RXData_Out     (RXData_Out),
    .RXValid        (RXValid),
    .RXError        (RXError),
    .RXBusy         (RXBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // n one-cycle pulses followed by one idle cycle
  task automatic send_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 ECS3_In = 1'b1;
      @(negedge clk); #1 ECS3_In = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic finish_frame(input string tag, input logic exp_v, input logic exp_e,
                              input int exp_lat, input logic [15:0] exp_data);
    int   lat = 0;
    logic v = 1'b0;
    logic e = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (RXValid || RXError) begin
        lat = i; v = RXValid; e = RXError;
        break;
      end
    end
    check($sformatf("%s_lat", tag), lat, exp_lat);
    check($sformatf("%s_valid", tag), v, exp_v);
    check($sformatf("%s_error", tag), e, exp_e);
    check($sformatf("%s_data", tag), RXData_Out, exp_data);
    @(negedge clk);
    check($sformatf("%s_strobe_clr", tag), {RXValid, RXError}, 2'b00);
    check($sformatf("%s_idle", tag), RXBusy, 1'b0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   err_seen;
    nRST = 1'b0; RXSelect = 1'b1; ECS3_In = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", RXData_Out, 16'h0000);
    check("rst_valid", RXValid, 1'b0);
    check("rst_error", RXError, 1'b0);
    check("rst_busy", RXBusy, 1'b0);
    nRST = 1'b1;
    repeat (2) @(negedge clk);

    send_burst(1); send_burst(1); send_burst(1);
    finish_frame("w0000", 1'b1, 1'b0, 2, 16'h0000);

    send_burst(1); send_burst(1); send_burst(16);
    finish_frame("wFFFF", 1'b1, 1'b0, 2, 16'hFFFF);

    send_burst(6); send_burst(2); send_burst(1); send_burst(1); send_burst(1);
    finish_frame("w0012", 1'b1, 1'b0, 2, 16'h0012);

    // nibble1=7 and nibble2=F use the inverted coding
    send_burst(5); send_burst(4); send_burst(5); send_burst(4); send_burst(7);
    finish_frame("w8F70", 1'b1, 1'b0, 2, 16'h8F70);

    send_burst(4);
    finish_frame("noi3", 1'b0, 1'b1, 2, 16'h8F70);

    send_burst(2); send_burst(5);
    finish_frame("idx5", 1'b0, 1'b1, 2, 16'h8F70);

    send_burst(3); send_burst(2); send_burst(2);
    finish_frame("ind_order", 1'b0, 1'b1, 2, 16'h8F70);

    send_burst(17);
    finish_frame("burst17", 1'b0, 1'b1, 1, 16'h8F70);

    send_burst(6);
    finish_frame("timeout", 1'b0, 1'b1, TIMEOUT + 2, 16'h8F70);

    send_burst(6);
    #1 RXSelect = 1'b0;
    err_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (RXError || RXValid) err_seen++;
    end
    check("desel_busy", RXBusy, 1'b0);
    check("desel_silent", err_seen, 0);
    RXSelect = 1'b1;
    send_burst(6); send_burst(2); send_burst(1); send_burst(1); send_burst(1);
    finish_frame("resel_0012", 1'b1, 1'b0, 2, 16'h0012);

    send_burst(11); send_burst(1);
    check("pre_rst_busy", RXBusy, 1'b1);
    #1 nRST = 1'b0;
    #2;
    check("mid_rst_data", RXData_Out, 16'h0000);
    check("mid_rst_busy", RXBusy, 1'b0);
    check("mid_rst_strobes", {RXValid, RXError}, 2'b00);
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    send_burst(11); send_burst(1); send_burst(2); send_burst(3); send_burst(4);
    send_burst(11); send_burst(1); send_burst(3); send_burst(2); send_burst(4);
    send_burst(1);
    finish_frame("wA5C3", 1'b1, 1'b0, 2, 16'hA5C3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ecs3_rx.md
# ecs3_rx

Single-wire ECS3 receiver: counts pulse bursts on the ECS3 line, rebuilds the per-nibble encoder fields (NOI, Ind0, Ind1, Flag), decodes them back into a 16-bit word and presents it with a one-cycle valid strobe. It is the far-end counterpart of the ECS3 transmitter, shares its clock domain, and is enabled by the transmitter-side RXSelect line direction signal.

## Interface
- TIMEOUT, 16: max consecutive idle sampled cycles tolerated inside a frame before abort (≥4).
- ECS3_TRX_Clock  in  1  clock; line sampled on falling edge, all other logic on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- RXSelect  in  1  receive enable; 0 forces IDLE and ignores the line.
- ECS3_In  in  1  ECS3 line; each pulse is one clock high phase.
- RXData_Out  out  16  last decoded word; reset 16'h0000; holds until next valid frame.
- RXValid  out  1  one-cycle strobe, word on RXData_Out is new; reset 0.
- RXError  out  1  one-cycle strobe, frame aborted; reset 0.
- RXBusy  out  1  high while a frame is in progress (state ≠ IDLE); reset 0.

## Operation
- Sampling: negedge flop s captures ECS3_In; a rising edge seeing s=1 counts one pulse; the first rising edge seeing s=0 after ≥1 counted pulse ends the burst (burst value = pulse count, 1..16; a 17th pulse → error).
- Frame = two segments then a flags burst. Segment k (k=0 nibbles 0/1, k=1 nibbles 2/3; lo = nibble 2k, hi = nibble 2k+1):
  - NOI burst: count−1 = {NOI_hi[1:0], NOI_lo[1:0]}.
  - Ind0_lo if NOI_lo≠0; Ind1_lo if NOI_lo=2; Ind0_hi if NOI_hi≠0; Ind1_hi if NOI_hi=2; omitted bursts send nothing.
- Flags burst: count−1 = {F3,F2,F1,F0}, Fn = Flag of nibble n.
- Nibble encoding: Flag=1 iff popcount(nibble)>2, then the inverted nibble is coded; NOI = popcount of coded value (0..2); Ind = bit position +1 (bit0→1 … bit3→4), Ind0<Ind1. Decode: set indexed bits, invert if Flag.
- States: IDLE → (first counted pulse) NOI → IDX (per expected index, repeats) → next segment NOI or FLAGS → IDLE. After NOI burst with both fields 0, go directly to next NOI/FLAGS.
- Errors (→ RXError, IDLE, RXData_Out unchanged): NOI field =3; index burst >4; Ind1 ≤ Ind0; burst >16; idle gap inside frame > TIMEOUT cycles.
- RXSelect deasserted mid-frame: silent abort to IDLE, no strobe.

## Timing
- Pulse in high phase of cycle k is counted at rising edge k+1.
- RXValid and new RXData_Out appear at the rising edge that detects the end of the flags burst; RXValid high exactly one cycle.
- Inter-burst gap ≥1 sampled zero is sufficient; gap counter resets on every counted pulse and starts only in non-IDLE states.
- A pulse at the rising edge that ends a frame starts a new frame next cycle (back-to-back frames supported).
- Async reset mid-frame: all outputs and state to reset values immediately; next frame decoded normally.

## Structure
- Shared package: state encodings, NOI/Ind widths, index base (1), max burst (16).
- Sub-module ecs3_decoder: combinational {NOI, Ind0, Ind1, Flag} → 4-bit nibble, used 4× or time-shared at frame end.

## Test plan
- 16'h0000: bursts 1,1,1 → RXValid, RXData_Out=16'h0000, no RXError.
- 16'hFFFF: bursts 1,1,16 → RXData_Out=16'hFFFF.
- 16'h0012: bursts 6,2,1,1,1 → RXData_Out=16'h0012.
- NOI burst of 4 (low field 3) → RXError one cycle, RXBusy 0 next cycle, RXData_Out unchanged.
- Burst 6 then line idle 20 cycles → RXError after TIMEOUT+1 idle cycles.
- nRST low mid-frame then full 16'hA5C3 frame → outputs zero during reset, then RXData_Out=16'hA5C3.
